lfsr_seq_checker: RTL and testbench
===================================

Name: lfsr_seq_checker

Overview:
- Downstream consumer of the 3-bit LFSR generator.
- Samples the generator's parallel state word each valid cycle, self-synchronises to the sequence, and declares lock.
- Once locked, predicts every following word and flags and counts mismatches.
- Used as the on-chip pass/fail monitor for the LFSR BIST path.

Parameters:
WIDTH, 3, LFSR state width; must match the generator.
TAPS, 3'b110, feedback mask (Fibonacci): fb = XOR of s[i] where TAPS[i]=1; next(s) = {s[WIDTH-2:0], fb}.
LOCK_CNT, 3, consecutive correct predictions needed to enter LOCKED (1..15).
MISS_LIMIT, 3, consecutive mismatches in LOCKED that force return to SEARCH (1..15).
CNT_W, 8, width of the saturating error and word counters.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
din  in  WIDTH  LFSR state word (generator output q).
din_valid  in  1  din is sampled on this edge.
locked  out  1  checker is in LOCKED.
err  out  1  one-cycle pulse: locked word mismatched its prediction.
err_count  out  CNT_W  mismatches since reset; saturates at all-ones.
word_count  out  CNT_W  valid words checked while LOCKED; saturates.

Behaviour:
Reset:
- rst high at an edge: locked=0, err=0, err_count=0, word_count=0, state=SEARCH, exp=0, have_seed=0, run=0.
- Reset overrides din_valid on the same edge.
- Reset mid-lock clears everything on that edge.

General rules:
- All outputs are registered; response appears after the edge that sampled din.
- din_valid=0: every register holds; err is forced to 0.

SEARCH (on valid):
- din==0: illegal stuck word. have_seed=0, run=0, no err.
- have_seed=0 and din!=0: exp=next(din), have_seed=1, run=0.
- have_seed=1 and din==exp:
  - If run+1==LOCK_CNT: enter LOCKED, locked=1 on this edge, exp=next(din), run=0.
  - Otherwise: run=run+1, exp=next(din).
- have_seed=1 and din!=exp (nonzero): re-seed. exp=next(din), run=0.
- err never asserts in SEARCH; err_count is not touched.

LOCKED (on valid):
- exp=next(exp) every valid word. The reference runs free; it is not reloaded from din, so a single corrupted word costs exactly one error.
- word_count increments, saturating.
- din==exp: miss=0.
- din!=exp:
  - err=1 for this cycle; err_count increments, saturating at 2^CNT_W-1; miss=miss+1.
  - If miss+1==MISS_LIMIT: go to SEARCH, locked=0, have_seed=0, run=0, miss=0. err still pulses for this last mismatch.

Other rules:
- Counter saturation: at all-ones the counter holds; it never wraps.
- Counters survive loss of lock; only rst clears them.
- Arithmetic is unsigned modulo the internal width; run and miss are 4 bits.

Reference sequence (WIDTH=3, TAPS=110, seed 001), period 7:
001, 010, 101, 011, 111, 110, 100, 001, ...

Test Plan:
1. Reset: assert rst 2 cycles with din_valid=1, din=001 -> locked=0, err=0, err_count=0, word_count=0 throughout and on the first edge after release of rst.
2. Lock: feed 001,010,101,011 with valid each cycle -> locked rises at the edge sampling 011; feed 111,110,100 -> err stays 0, word_count=3.
3. Single error: locked, feed 111 replaced by 000, then 110,100 -> err pulses once, err_count=1, locked stays 1, next word matches.
4. Loss of lock: locked, feed 3 wrong words (000,000,000) -> err pulses on each, err_count=3, locked falls at the third edge. Resuming the correct sequence relocks after seed plus 3 matches.
5. Stuck/gaps: din=000 for 10 valid cycles -> never locks, err_count=0. In LOCKED, deassert din_valid 5 cycles -> all outputs hold, err=0, and the sequence continues correctly afterwards.
6. Saturation and mid-run reset:
   - CNT_W=2, locked, 5 mismatches spaced by good words (MISS_LIMIT=3) -> err_count sticks at 3.
   - Assert rst while locked -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/lfsr_seq_checker.sv
// ---------------------------------------------------------------------------
// lfsr_seq_checker
//
// Purpose:
//   Pass/fail monitor for an LFSR BIST path. It watches the generator's
//   parallel state word and first synchronises to the sequence (SEARCH).
//   After LOCK_CNT consecutive correct predictions it declares lock (LOCKED).
//   In LOCKED an internal reference LFSR runs freely, one step per valid
//   word. The checker flags and counts every word that disagrees with the
//   reference. After MISS_LIMIT consecutive mismatches it drops back to
//   SEARCH.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   rst         in   1      synchronous active-high reset
//   din         in   WIDTH  LFSR state word from the generator
//   din_valid   in   1      din is sampled on this edge
//   locked      out  1      checker is in LOCKED
//   err         out  1      one-cycle pulse: locked word mismatched prediction
//   err_count   out  CNT_W  mismatches since reset, saturating
//   word_count  out  CNT_W  valid words checked while LOCKED, saturating
// ---------------------------------------------------------------------------
module lfsr_seq_checker #(
  parameter int               WIDTH      = 3,
  parameter logic [WIDTH-1:0] TAPS       = 3'b110,
  parameter int               LOCK_CNT   = 3,
  parameter int               MISS_LIMIT = 3,
  parameter int               CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [3:0] LOCK_CNT_C   = 4'(LOCK_CNT);
  localparam logic [3:0] MISS_LIMIT_C = 4'(MISS_LIMIT);

  // Fibonacci step: feedback is the parity of the tapped bits, shifted in
  // at the LSB.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    logic fb;
    fb = ^(s & TAPS);
    return {s[WIDTH-2:0], fb};
  endfunction

  // Saturating increment: the counter holds at all-ones and never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] exp_q,       exp_d;
  logic             have_seed_q, have_seed_d;
  logic [3:0]       run_q,       run_d;
  logic [3:0]       miss_q,      miss_d;
  logic             err_q,       err_d;
  logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
  logic [CNT_W-1:0] word_cnt_q,  word_cnt_d;

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    have_seed_d = have_seed_q;
    run_d       = run_q;
    miss_d      = miss_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;

    if (din_valid) begin
      case (state_q)
        SEARCH: begin
          if (din == '0) begin
            // The all-zero word is the LFSR lock-up state and never part of
            // a valid sequence, so it cannot serve as a seed.
            have_seed_d = 1'b0;
            run_d       = 4'd0;
          end else if (!have_seed_q) begin
            exp_d       = lfsr_next(din);
            have_seed_d = 1'b1;
            run_d       = 4'd0;
          end else if (din == exp_q) begin
            exp_d = lfsr_next(din);
            if (run_q + 4'd1 == LOCK_CNT_C) begin
              state_d = LOCKED;
              run_d   = 4'd0;
            end else begin
              run_d = run_q + 4'd1;
            end
          end else begin
            // Wrong but nonzero: treat it as a fresh seed.
            exp_d = lfsr_next(din);
            run_d = 4'd0;
          end
        end

        LOCKED: begin
          // Free-running reference. It is never reloaded from din, so one
          // corrupted word produces exactly one error.
          exp_d      = lfsr_next(exp_q);
          word_cnt_d = sat_inc(word_cnt_q);
          if (din == exp_q) begin
            miss_d = 4'd0;
          end else begin
            err_d     = 1'b1;
            err_cnt_d = sat_inc(err_cnt_q);
            if (miss_q + 4'd1 == MISS_LIMIT_C) begin
              state_d     = SEARCH;
              have_seed_d = 1'b0;
              run_d       = 4'd0;
              miss_d      = 4'd0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
        end

        default: begin
          state_d = SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      exp_q       <= '0;
      have_seed_q <= 1'b0;
      run_q       <= 4'd0;
      miss_q      <= 4'd0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      have_seed_q <= have_seed_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign err        = err_q;
  assign err_count  = err_cnt_q;
  assign word_count = word_cnt_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_seq_checker
//
// Two checkers share one stimulus stream: the default instance (CNT_W=8) and
// a narrow instance (CNT_W=2) used to watch counter saturation. Each driven
// word pushes its expected post-edge outputs to a scoreboard queue. A monitor
// pops the entry one time unit after the edge and compares.
// ---------------------------------------------------------------------------
module tb_lfsr_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] din = 3'b000;
  logic       din_valid = 1'b0;

  logic       locked_a, err_a;
  logic [7:0] err_count_a, word_count_a;
  logic       locked_b, err_b;
  logic [1:0] err_count_b, word_count_b;

  always #5 clk = ~clk;

  lfsr_seq_checker #(.CNT_W(8)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .locked    (locked_a),
    .err       (err_a),
    .err_count (err_count_a),
    .word_count(word_count_a)
  );

  lfsr_seq_checker #(.CNT_W(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .locked    (locked_b),
    .err       (err_b),
    .err_count (err_count_b),
    .word_count(word_count_b)
  );

  typedef struct {
    logic l;
    logic e;
    int   ec;
    int   wc;
    int   ec2;
    int   wc2;
  } exp_t;

  exp_t sb_q[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // Expected-state model: locked and err are hand-derived per step. The
  // counters follow from them. Errors add to err_count. Valid words seen
  // while already locked add to word_count.
  logic m_locked = 1'b0;
  int   m_ec = 0, m_wc = 0, m_ec2 = 0, m_wc2 = 0;

  task automatic step(input logic r, input logic v, input logic [2:0] d,
                      input logic el, input logic ee);
    exp_t x;
    @(negedge clk);
    rst       = r;
    din_valid = v;
    din       = d;
    if (r) begin
      m_ec = 0; m_wc = 0; m_ec2 = 0; m_wc2 = 0;
    end else if (v) begin
      if (ee) begin
        if (m_ec  < 255) m_ec++;
        if (m_ec2 < 3)   m_ec2++;
      end
      if (m_locked) begin
        if (m_wc  < 255) m_wc++;
        if (m_wc2 < 3)   m_wc2++;
      end
    end
    m_locked = el;
    x.l = el; x.e = ee; x.ec = m_ec; x.wc = m_wc; x.ec2 = m_ec2; x.wc2 = m_wc2;
    sb_q.push_back(x);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      chk("locked_a",     32'(locked_a),     32'(x.l));
      chk("err_a",        32'(err_a),        32'(x.e));
      chk("err_count_a",  32'(err_count_a),  32'(x.ec));
      chk("word_count_a", 32'(word_count_a), 32'(x.wc));
      chk("locked_b",     32'(locked_b),     32'(x.l));
      chk("err_b",        32'(err_b),        32'(x.e));
      chk("err_count_b",  32'(err_count_b),  32'(x.ec2));
      chk("word_count_b", 32'(word_count_b), 32'(x.wc2));
    end
  end

  initial begin
    // Reset held with valid data present.
    step(1, 1, 3'b001, 0, 0);
    step(1, 1, 3'b001, 0, 0);

    // Seed and three matches: lock at the edge sampling 011.
    step(0, 1, 3'b001, 0, 0);
    step(0, 1, 3'b010, 0, 0);
    step(0, 1, 3'b101, 0, 0);
    step(0, 1, 3'b011, 1, 0);
    step(0, 1, 3'b111, 1, 0);
    step(0, 1, 3'b110, 1, 0);
    step(0, 1, 3'b100, 1, 0);

    // One corrupted word (111 replaced by 000).
    step(0, 1, 3'b001, 1, 0);
    step(0, 1, 3'b010, 1, 0);
    step(0, 1, 3'b101, 1, 0);
    step(0, 1, 3'b011, 1, 0);
    step(0, 1, 3'b000, 1, 1);
    step(0, 1, 3'b110, 1, 0);
    step(0, 1, 3'b100, 1, 0);

    // Three consecutive mismatches drop lock on the third.
    step(0, 1, 3'b000, 1, 1);
    step(0, 1, 3'b000, 1, 1);
    step(0, 1, 3'b000, 0, 1);
    // Relock: seed plus three matches.
    step(0, 1, 3'b111, 0, 0);
    step(0, 1, 3'b110, 0, 0);
    step(0, 1, 3'b100, 0, 0);
    step(0, 1, 3'b001, 1, 0);
    step(0, 1, 3'b010, 1, 0);

    // Reset while locked clears everything on that edge.
    step(1, 1, 3'b101, 0, 0);
    // A stuck all-zero word never locks.
    for (int i = 0; i < 10; i++) step(0, 1, 3'b000, 0, 0);

    // Lock, then a five-cycle gap in din_valid.
    step(0, 1, 3'b001, 0, 0);
    step(0, 1, 3'b010, 0, 0);
    step(0, 1, 3'b101, 0, 0);
    step(0, 1, 3'b011, 1, 0);
    step(0, 1, 3'b111, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 3'b000, 1, 0);
    step(0, 1, 3'b110, 1, 0);
    step(0, 1, 3'b100, 1, 0);

    // Five isolated mismatches: the narrow counter sticks at 3.
    step(0, 1, 3'b000, 1, 1);
    step(0, 1, 3'b010, 1, 0);
    step(0, 1, 3'b110, 1, 1);
    step(0, 1, 3'b011, 1, 0);
    step(0, 1, 3'b000, 1, 1);
    step(0, 1, 3'b110, 1, 0);
    step(0, 1, 3'b000, 1, 1);
    step(0, 1, 3'b001, 1, 0);
    step(0, 1, 3'b111, 1, 1);
    step(0, 1, 3'b101, 1, 0);

    // Reset while locked, then one word of fresh search.
    step(1, 1, 3'b011, 0, 0);
    step(0, 1, 3'b001, 0, 0);

    @(negedge clk);
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
